cfg_chain_loader: RTL and testbench



---
 rtl/cfg_chain_loader.sv | 119 +++++++++++
 tb/tb_cfg_chain_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises plaintext blocks MSB-first onto the configuration chain, then checks the chain tail
module cfg_chain_loader #(
   parameter int CHAIN_LEN   = 4096,
   parameter int RST_CYCLES  = 4,
   parameter int BLK_TIMEOUT = 1024
) (
   input  logic         tck_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic         blk_valid_i,
   input  logic [127:0] blk_data_i,
   output logic         blk_ready_o,
   output logic         progclk_o,
   output logic         pReset_o,
   output logic         data_o,
   input  logic         ccff_tail_i,
   output logic         fpga_clk_en_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [1:0]   err_code_o,
   output logic [15:0]  bit_cnt_o
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam int TW = $clog2(BLK_TIMEOUT + 1);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(BLK_TIMEOUT - 1);
   localparam logic [15:0]   LAST_BIT = 16'(CHAIN_LEN);
   typedef enum logic [2:0] {IDLE, RESET, WAIT_BLK, SHIFT_LO, SHIFT_HI, CHECK, DONE, ERROR} state_t;
   state_t         state_q;
   logic           progclk_q, preset_q, data_q, first_q;
   logic [127:0]   shreg_q;
   logic [6:0]     idx_q;
   logic [15:0]    bit_cnt_q;
   logic [1:0]     err_code_q;
   logic [TW-1:0]  tmo_q;
   logic [RW-1:0]  rst_cnt_q;
   assign blk_ready_o   = state_q == WAIT_BLK;
   assign fpga_clk_en_o = state_q == DONE;
   assign done_o        = state_q == DONE;
   assign err_o         = state_q == ERROR;
   assign busy_o        = state_q inside {RESET, WAIT_BLK, SHIFT_LO, SHIFT_HI, CHECK};
   assign progclk_o     = progclk_q;
   assign pReset_o      = preset_q;
   assign data_o        = data_q;
   assign err_code_o    = err_code_q;
   assign bit_cnt_o     = bit_cnt_q;
   always_ff @(posedge tck_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         progclk_q  <= 1'b0;
         preset_q   <= 1'b0;
         data_q     <= 1'b0;
         first_q    <= 1'b0;
         shreg_q    <= '0;
         idx_q      <= '0;
         bit_cnt_q  <= '0;
         err_code_q <= '0;
         tmo_q      <= '0;
         rst_cnt_q  <= '0;
      end else if (abort_i) begin
         state_q    <= IDLE;
         progclk_q  <= 1'b0;
         preset_q   <= 1'b0;
         data_q     <= 1'b0;
         err_code_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
               state_q    <= RESET;
               preset_q   <= 1'b1;
               data_q     <= 1'b0;
               bit_cnt_q  <= '0;
               err_code_q <= '0;
               tmo_q      <= '0;
               rst_cnt_q  <= '0;
            end
            RESET: if (rst_cnt_q == RST_LAST) begin
               preset_q <= 1'b0;
               state_q  <= WAIT_BLK;
            end else rst_cnt_q <= rst_cnt_q + RW'(1);
            WAIT_BLK: if (blk_valid_i) begin
               shreg_q <= blk_data_i;
               data_q  <= blk_data_i[127];
               idx_q   <= '0;
               tmo_q   <= '0;
               state_q <= SHIFT_LO;
            end else if (tmo_q == TMO_LAST) begin
               err_code_q <= 2'd1;
               state_q    <= ERROR;
            end else tmo_q <= tmo_q + TW'(1);
            SHIFT_LO: begin
               progclk_q <= 1'b1;
               state_q   <= SHIFT_HI;
            end
            SHIFT_HI: begin
               progclk_q <= 1'b0;
               shreg_q   <= {shreg_q[126:0], 1'b0};
               bit_cnt_q <= bit_cnt_q + 16'd1;
               idx_q     <= idx_q + 7'd1;
               if (bit_cnt_q == 16'd0) first_q <= data_q;
               // data_o only moves when the next bit is presented, so it stays put across block waits
               if (bit_cnt_q + 16'd1 == LAST_BIT) state_q <= CHECK;
               else if (idx_q == 7'd127) state_q <= WAIT_BLK;
               else begin
                  data_q  <= shreg_q[126];
                  state_q <= SHIFT_LO;
               end
            end
            CHECK: if (ccff_tail_i == first_q) state_q <= DONE;
            else begin
               err_code_q <= 2'd2;
               state_q    <= ERROR;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: directed checks of block loading, partial block, timeout, broken chain, abort and async reset
module tb_cfg_chain_loader;
   logic tck_i = 1'b0, rst_i = 1'b0, abort_i = 1'b0, blk_valid_i = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, broken = 1'b0, sel = 1'b0;
   logic [127:0] blk_data_i = '0;
   logic rdy_a, pclk_a, prst_a, data_a, fen_a, busy_a, done_a, err_a, tail_a;
   logic rdy_b, pclk_b, prst_b, data_b, fen_b, busy_b, done_b, err_b, tail_b;
   logic [1:0] code_a, code_b;
   logic [15:0] bcnt_a, bcnt_b;
   logic [255:0] chain_a = '0;
   logic [199:0] chain_b = '0;
   int edges_a = 0, edges_b = 0, prst_cyc_a = 0, cyc = 0;
   int n_chk = 0, n_pass = 0;
   localparam logic [127:0] B1 = {1'b1, 126'd0, 1'b1};
   localparam logic [127:0] B2 = {128{1'b1}};
   localparam logic [127:0] B3 = 128'h0123456789ABCDEF_FEDCBA9876543210;
   cfg_chain_loader #(.CHAIN_LEN(256), .RST_CYCLES(4), .BLK_TIMEOUT(16)) dut_a (
      .tck_i(tck_i), .rst_i(rst_i), .start_i(start_a), .abort_i(abort_i),
      .blk_valid_i(blk_valid_i), .blk_data_i(blk_data_i), .blk_ready_o(rdy_a),
      .progclk_o(pclk_a), .pReset_o(prst_a), .data_o(data_a), .ccff_tail_i(tail_a),
      .fpga_clk_en_o(fen_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
      .err_code_o(code_a), .bit_cnt_o(bcnt_a));
   cfg_chain_loader #(.CHAIN_LEN(200), .RST_CYCLES(4), .BLK_TIMEOUT(16)) dut_b (
      .tck_i(tck_i), .rst_i(rst_i), .start_i(start_b), .abort_i(abort_i),
      .blk_valid_i(blk_valid_i), .blk_data_i(blk_data_i), .blk_ready_o(rdy_b),
      .progclk_o(pclk_b), .pReset_o(prst_b), .data_o(data_b), .ccff_tail_i(tail_b),
      .fpga_clk_en_o(fen_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
      .err_code_o(code_b), .bit_cnt_o(bcnt_b));
   always #5 tck_i = ~tck_i;
   always @(posedge tck_i) cyc++;
   always @(negedge tck_i) if (prst_a) prst_cyc_a++;
   always @(posedge pclk_a) begin
      chain_a <= {chain_a[254:0], data_a};
      edges_a++;
   end
   always @(posedge pclk_b) begin
      chain_b <= {chain_b[198:0], data_b};
      edges_b++;
   end
   // a 255-flop chain taps one stage early
   assign tail_a = broken ? chain_a[254] : chain_a[255];
   assign tail_b = chain_b[199];
   function automatic logic [25:0] outs_a();
      return {pclk_a, prst_a, data_a, rdy_a, fen_a, busy_a, done_a, err_a, code_a, bcnt_a};
   endfunction
   function automatic logic cnd(input int w);
      case (w)
         0: return done_a | err_a;
         1: return sel ? rdy_b : rdy_a;
         2: return done_b | err_b;
         3: return bcnt_a == 16'd70;
         default: return pclk_a;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge tck_i);
      #1;
   endtask
   task automatic wait_until(input int w, input int lim, input string tag);
      for (int i = 0; i < lim && !cnd(w); i++) tick();
      if (!cnd(w)) chk(tag, 0, 1);
   endtask
   task automatic send(input logic [127:0] b);
      blk_data_i  = b;
      blk_valid_i = 1'b1;
      wait_until(1, 2000, "ready_timeout");
      tick();
      blk_valid_i = 1'b0;
   endtask
   initial begin
      int c0, e0, p0, n;
      repeat (3) tick();
      chk("reset_outs_a", outs_a(), 0);
      chk("reset_outs_b", {busy_b, done_b, err_b, pclk_b, bcnt_b}, 0);
      rst_i = 1'b1;
      tick();
      // nominal 256-bit load, best-case latency 1+4+2+512+1
      c0 = cyc;
      p0 = prst_cyc_a;
      e0 = edges_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("start_busy", {busy_a, prst_a}, 2'b11);
      send(B1);
      send(B2);
      wait_until(0, 1000, "nominal_timeout");
      chk("nominal_latency", cyc - c0, 520);
      chk("nominal_flags", {done_a, fen_a, err_a, busy_a, code_a}, 6'b110000);
      chk("nominal_bitcnt", bcnt_a, 256);
      chk("nominal_edges", edges_a - e0, 256);
      chk("nominal_bits", chain_a, {B1, B2});
      chk("nominal_preset_cycles", prst_cyc_a - p0, 4);
      // broken chain: second bit lands in the tail instead of the first
      broken = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("restart_clears_done", {done_a, fen_a, busy_a}, 3'b001);
      send(B1);
      send(B2);
      wait_until(0, 1000, "broken_timeout");
      chk("broken_flags", {done_a, err_a, code_a}, 4'b0110);
      broken = 1'b0;
      // starvation after the first block
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("start_clears_code", {err_a, code_a, busy_a}, 4'b0001);
      send(B1);
      wait_until(1, 1000, "wait_entry_timeout");
      e0 = edges_a;
      n = 0;
      while (!err_a && n < 100) begin
         tick();
         n++;
      end
      chk("timeout_cycles", n, 16);
      chk("timeout_flags", {err_a, code_a, pclk_a}, 4'b1010);
      chk("timeout_no_edges", edges_a - e0, 0);
      blk_valid_i = 1'b1;
      repeat (3) tick();
      chk("error_not_ready", {rdy_a, err_a}, 2'b01);
      blk_valid_i = 1'b0;
      // abort mid-shift
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      send(B2);
      wait_until(3, 1000, "bit70_timeout");
      chk("pre_abort_data", data_a, 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_outs", {pclk_a, prst_a, data_a, busy_a, done_a, err_a, code_a}, 0);
      p0 = prst_cyc_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_until(1, 100, "restart_ready_timeout");
      chk("restart_preset_cycles", prst_cyc_a - p0, 4);
      chk("restart_preset_low", prst_a, 0);
      // async reset while the chain clock is high
      send(B2);
      wait_until(4, 100, "shift_hi_timeout");
      #1 rst_i = 1'b0;
      #1 chk("async_reset_outs", outs_a(), 0);
      e0 = edges_a;
      repeat (3) tick();
      chk("async_reset_no_edges", edges_a - e0, 0);
      rst_i = 1'b1;
      tick();
      // partial final block on the 200-bit loader
      sel = 1'b1;
      e0 = edges_b;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      send(B1);
      send(B3);
      wait_until(2, 1000, "partial_timeout");
      chk("partial_flags", {done_b, fen_b, err_b, code_b}, 5'b11000);
      chk("partial_bitcnt", bcnt_b, 200);
      chk("partial_edges", edges_b - e0, 200);
      chk("partial_bits", chain_b, {B1, B3[127:56]});
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
